// File: rtl/tlb_inv_seq_pkg.sv
// Shared definitions for the INVTLB sequencer: op encodings, FSM states
// and page-size constants.
package tlb_inv_seq_pkg;

  localparam int TLBNUM_DEFAULT = 16;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  localparam logic [4:0] INV_ALL        = 5'd0;
  localparam logic [4:0] INV_ALL_ALT    = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_ASID_VA    = 5'd6;
  localparam logic [4:0] INV_OP_MAX     = INV_ASID_VA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A 4K page compares the full VPPN; any larger page compares the upper 10 bits.
  function automatic logic va_hit(input logic [5:0]  ps,
                                  input logic [18:0] entry_vppn,
                                  input logic [18:0] vppn);
    if (ps == PS_4K) return (entry_vppn == vppn);
    else             return (entry_vppn[18:9] == vppn[18:9]);
  endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB entry-selection predicate for one TLB entry.
module tlb_inv_match
  import tlb_inv_seq_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [9:0]  asid,
  input  logic [18:0] vppn,
  input  logic        r_g,
  input  logic [5:0]  r_ps,
  input  logic [9:0]  r_asid,
  input  logic [18:0] r_vppn,
  output logic        match
);

  logic asid_eq;
  logic va_eq;

  always_comb begin
    asid_eq = (r_asid == asid);
    va_eq   = va_hit(r_ps, r_vppn, vppn);
    match   = 1'b0;
    case (op)
      INV_ALL,
      INV_ALL_ALT:    match = 1'b1;
      INV_G:          match = r_g;
      INV_NG:         match = ~r_g;
      INV_NG_ASID:    match = ~r_g & asid_eq;
      INV_NG_ASID_VA: match = ~r_g & asid_eq & va_eq;
      INV_ASID_VA:    match = (r_g | asid_eq) & va_eq;
      default:        match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer: walks every TLB entry once, clearing E on entries
// selected by the latched op/asid/vppn.
//
// state | meaning
// IDLE  | waiting for inv_req; operands latched on accept
// WALK  | one entry per cycle, idx 0..TLBNUM-1, write-back of E=0 on match
// DONE  | one-cycle inv_done pulse with inv_err
module tlb_inv_seq
  import tlb_inv_seq_pkg::*;
#(
  parameter int TLBNUM = TLBNUM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inv_req,
  input  logic [4:0]                inv_op,
  input  logic [9:0]                inv_asid,
  input  logic [18:0]               inv_vppn,
  input  logic                      inv_kill,
  output logic                      inv_busy,
  output logic                      inv_done,
  output logic                      inv_err,
  output logic [$clog2(TLBNUM)-1:0] r_index,
  input  logic                      r_e,
  input  logic                      r_g,
  input  logic [5:0]                r_ps,
  input  logic [9:0]                r_asid,
  input  logic [18:0]               r_vppn,
  output logic                      we,
  output logic [$clog2(TLBNUM)-1:0] w_index,
  output logic                      w_e
);

  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(TLBNUM - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [4:0]      op_q, op_d;
  logic [9:0]      asid_q, asid_d;
  logic [18:0]     vppn_q, vppn_d;
  logic            err_q, err_d;
  logic            match;

  tlb_inv_match u_match (
    .op     (op_q),
    .asid   (asid_q),
    .vppn   (vppn_q),
    .r_g    (r_g),
    .r_ps   (r_ps),
    .r_asid (r_asid),
    .r_vppn (r_vppn),
    .match  (match)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    asid_d   = asid_q;
    vppn_d   = vppn_q;
    err_d    = err_q;
    inv_busy = 1'b0;
    inv_done = 1'b0;
    inv_err  = 1'b0;
    we       = 1'b0;
    w_index  = '0;
    r_index  = '0;
    w_e      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inv_req && !inv_kill) begin
          op_d   = inv_op;
          asid_d = inv_asid;
          vppn_d = inv_vppn;
          idx_d  = '0;
          if (inv_op <= INV_OP_MAX) begin
            err_d   = 1'b0;
            state_d = ST_WALK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_WALK: begin
        inv_busy = 1'b1;
        r_index  = idx_q;
        w_index  = idx_q;
        we       = r_e & match;
        idx_d    = idx_q + IDXW'(1);
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        inv_busy = 1'b1;
        inv_done = 1'b1;
        inv_err  = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush abandons the walk outright: no further writes, no completion.
    if (inv_kill) begin
      state_d  = ST_IDLE;
      we       = 1'b0;
      inv_done = 1'b0;
      inv_err  = 1'b0;
    end

    // Outputs are quiet in the reset cycle itself, so a reset mid-walk never writes.
    if (reset) begin
      inv_busy = 1'b0;
      inv_done = 1'b0;
      inv_err  = 1'b0;
      we       = 1'b0;
      w_index  = '0;
      r_index  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Directed bench for tlb_inv_seq: behavioural TLB array feeds the read port.
module tb_tlb_inv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        inv_req;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        inv_kill;
  logic        inv_busy, inv_done, inv_err;
  logic [3:0]  r_index;
  logic        r_e, r_g;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  logic        we;
  logic [3:0]  w_index;
  logic        w_e;

  logic        tlb_e    [16];
  logic        tlb_g    [16];
  logic [5:0]  tlb_ps   [16];
  logic [9:0]  tlb_asid [16];
  logic [18:0] tlb_vppn [16];

  int n_chk  = 0;
  int n_pass = 0;
  int wl_idx[$];
  int wl_cyc[$];
  int done_k;
  logic done_err;

  always #5 clk = ~clk;

  always_comb begin
    r_e    = tlb_e[r_index];
    r_g    = tlb_g[r_index];
    r_ps   = tlb_ps[r_index];
    r_asid = tlb_asid[r_index];
    r_vppn = tlb_vppn[r_index];
  end

  tlb_inv_seq #(.TLBNUM(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .inv_req  (inv_req),
    .inv_op   (inv_op),
    .inv_asid (inv_asid),
    .inv_vppn (inv_vppn),
    .inv_kill (inv_kill),
    .inv_busy (inv_busy),
    .inv_done (inv_done),
    .inv_err  (inv_err),
    .r_index  (r_index),
    .r_e      (r_e),
    .r_g      (r_g),
    .r_ps     (r_ps),
    .r_asid   (r_asid),
    .r_vppn   (r_vppn),
    .we       (we),
    .w_index  (w_index),
    .w_e      (w_e)
  );

  task automatic clear_tlb(input logic e, input logic g);
    for (int i = 0; i < 16; i++) begin
      tlb_e[i] = e; tlb_g[i] = g; tlb_ps[i] = 6'd12;
      tlb_asid[i] = 10'd0; tlb_vppn[i] = 19'd0;
    end
  endtask

  task automatic set_entry(input int i, input logic g, input logic [5:0] ps,
                           input logic [9:0] asid, input logic [18:0] vppn);
    tlb_e[i] = 1'b1; tlb_g[i] = g; tlb_ps[i] = ps;
    tlb_asid[i] = asid; tlb_vppn[i] = vppn;
  endtask

  // Issues one request, then logs writes (cycle k after accept) until inv_done.
  // Operand inputs are scrambled after accept so only latched copies can work.
  task automatic run_walk(input logic [4:0] op, input logic [9:0] asid,
                          input logic [18:0] vppn, input int budget);
    wl_idx.delete(); wl_cyc.delete();
    done_k = -1; done_err = 1'b0;
    @(posedge clk); #1;
    inv_req = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    @(negedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      inv_req = 1'b0; inv_op = 5'h1f; inv_asid = 10'h3ff; inv_vppn = ~vppn;
      @(negedge clk);
      if (we) begin wl_idx.push_back(int'(w_index)); wl_cyc.push_back(k); end
      if (inv_done) begin done_k = k; done_err = inv_err; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; inv_req = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0; inv_kill = 1'b0;
    clear_tlb(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++; if (inv_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", inv_busy); else n_pass++;
    n_chk++; if (inv_done !== 1'b0) $display("FAIL rst_done: got %b want 0", inv_done); else n_pass++;
    n_chk++; if (inv_err !== 1'b0) $display("FAIL rst_err: got %b want 0", inv_err); else n_pass++;
    n_chk++; if (we !== 1'b0) $display("FAIL rst_we: got %b want 0", we); else n_pass++;
    n_chk++; if (w_index !== 4'd0) $display("FAIL rst_w_index: got %0d want 0", w_index); else n_pass++;
    n_chk++; if (r_index !== 4'd0) $display("FAIL rst_r_index: got %0d want 0", r_index); else n_pass++;
    n_chk++; if (w_e !== 1'b0) $display("FAIL rst_w_e: got %b want 0", w_e); else n_pass++;
  endtask

  task automatic test_op0_all;
    clear_tlb(1'b1, 1'b0);
    run_walk(5'd0, 10'd0, 19'd0, 30);
    n_chk++; if (wl_idx.size() !== 16) $display("FAIL op0_nwrites: got %0d want 16", wl_idx.size()); else n_pass++;
    for (int i = 0; i < wl_idx.size(); i++) begin
      n_chk++;
      if (wl_idx[i] !== i || wl_cyc[i] !== i + 1)
        $display("FAIL op0_write%0d: got idx %0d cyc %0d want idx %0d cyc %0d", i, wl_idx[i], wl_cyc[i], i, i + 1);
      else n_pass++;
    end
    n_chk++; if (done_k !== 17) $display("FAIL op0_done_cyc: got %0d want 17", done_k); else n_pass++;
    n_chk++; if (done_err !== 1'b0) $display("FAIL op0_err: got %b want 0", done_err); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (inv_done !== 1'b0) $display("FAIL op0_done_once: got %b want 0", inv_done); else n_pass++;
    n_chk++; if (inv_busy !== 1'b0) $display("FAIL op0_idle_busy: got %b want 0", inv_busy); else n_pass++;
  endtask

  task automatic test_op4_asid;
    clear_tlb(1'b0, 1'b0);
    set_entry(3, 1'b0, 6'd12, 10'h005, 19'h0);
    set_entry(7, 1'b1, 6'd12, 10'h005, 19'h0);
    set_entry(9, 1'b0, 6'd12, 10'h006, 19'h0);
    run_walk(5'd4, 10'h005, 19'h0, 30);
    n_chk++; if (wl_idx.size() !== 1) $display("FAIL op4_nwrites: got %0d want 1", wl_idx.size()); else n_pass++;
    if (wl_idx.size() > 0) begin
      n_chk++;
      if (wl_idx[0] !== 3 || wl_cyc[0] !== 4)
        $display("FAIL op4_write: got idx %0d cyc %0d want idx 3 cyc 4", wl_idx[0], wl_cyc[0]);
      else n_pass++;
    end
    n_chk++; if (done_k !== 17) $display("FAIL op4_done_cyc: got %0d want 17", done_k); else n_pass++;
  endtask

  task automatic test_op5_va;
    clear_tlb(1'b0, 1'b0);
    set_entry(2, 1'b0, 6'd12, 10'd1, 19'h12345);
    set_entry(4, 1'b0, 6'd21, 10'd1, 19'h12200);
    set_entry(6, 1'b0, 6'd12, 10'd1, 19'h12344);
    run_walk(5'd5, 10'd1, 19'h12345, 30);
    n_chk++; if (wl_idx.size() !== 2) $display("FAIL op5_nwrites: got %0d want 2", wl_idx.size()); else n_pass++;
    if (wl_idx.size() == 2) begin
      n_chk++;
      if (wl_idx[0] !== 2 || wl_idx[1] !== 4)
        $display("FAIL op5_idx: got %0d,%0d want 2,4", wl_idx[0], wl_idx[1]);
      else n_pass++;
    end
    n_chk++; if (done_k !== 17) $display("FAIL op5_done_cyc: got %0d want 17", done_k); else n_pass++;
  endtask

  task automatic test_op6_global;
    clear_tlb(1'b0, 1'b0);
    set_entry(1,  1'b1, 6'd21, 10'd9, 19'h00500);
    set_entry(8,  1'b0, 6'd12, 10'd1, 19'h00400);
    set_entry(10, 1'b0, 6'd12, 10'd2, 19'h00400);
    tlb_g[12] = 1'b1; tlb_vppn[12] = 19'h00400;
    run_walk(5'd6, 10'd1, 19'h00400, 30);
    n_chk++; if (wl_idx.size() !== 2) $display("FAIL op6_nwrites: got %0d want 2", wl_idx.size()); else n_pass++;
    if (wl_idx.size() == 2) begin
      n_chk++;
      if (wl_idx[0] !== 1 || wl_idx[1] !== 8)
        $display("FAIL op6_idx: got %0d,%0d want 1,8", wl_idx[0], wl_idx[1]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal;
    clear_tlb(1'b1, 1'b0);
    run_walk(5'd7, 10'd0, 19'd0, 5);
    n_chk++; if (done_k !== 1) $display("FAIL ill7_done_cyc: got %0d want 1", done_k); else n_pass++;
    n_chk++; if (done_err !== 1'b1) $display("FAIL ill7_err: got %b want 1", done_err); else n_pass++;
    n_chk++; if (wl_idx.size() !== 0) $display("FAIL ill7_nwrites: got %0d want 0", wl_idx.size()); else n_pass++;
    run_walk(5'd31, 10'd0, 19'd0, 5);
    n_chk++; if (done_k !== 1 || done_err !== 1'b1)
      $display("FAIL ill31_done: got cyc %0d err %b want cyc 1 err 1", done_k, done_err); else n_pass++;
  endtask

  task automatic test_kill;
    int n_wr;
    int n_dn;
    clear_tlb(1'b1, 1'b0);
    n_wr = 0;
    @(posedge clk); #1;
    inv_req = 1'b1; inv_op = 5'd0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1 inv_req = 1'b0;
      @(negedge clk);
      if (we && int'(w_index) == k - 1) n_wr++;
    end
    n_chk++; if (n_wr !== 5) $display("FAIL kill_prewrites: got %0d want 5", n_wr); else n_pass++;
    @(posedge clk); #1 inv_kill = 1'b1;
    @(negedge clk);
    n_chk++; if (we !== 1'b0) $display("FAIL kill_we: got %b want 0", we); else n_pass++;
    @(posedge clk); #1 inv_kill = 1'b0;
    @(negedge clk);
    n_chk++; if (inv_busy !== 1'b0) $display("FAIL kill_idle: got busy %b want 0", inv_busy); else n_pass++;
    n_wr = 0; n_dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (we) n_wr++;
      if (inv_done) n_dn++;
    end
    n_chk++; if (n_wr !== 0 || n_dn !== 0)
      $display("FAIL kill_quiet: got writes %0d done %0d want 0 0", n_wr, n_dn); else n_pass++;
    @(posedge clk); #1 inv_req = 1'b1; inv_kill = 1'b1;
    @(posedge clk); #1 inv_req = 1'b0; inv_kill = 1'b0;
    @(negedge clk);
    n_chk++; if (inv_busy !== 1'b0) $display("FAIL kill_prio: got busy %b want 0", inv_busy); else n_pass++;
    run_walk(5'd3, 10'd0, 19'd0, 30);
    n_chk++; if (wl_idx.size() !== 16 || done_k !== 17)
      $display("FAIL kill_rerun: got writes %0d done %0d want 16 17", wl_idx.size(), done_k); else n_pass++;
  endtask

  task automatic test_reset_mid_walk;
    int n_dn;
    clear_tlb(1'b1, 1'b0);
    @(posedge clk); #1 inv_req = 1'b1; inv_op = 5'd0;
    @(posedge clk); #1 inv_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_chk++; if (we !== 1'b0 || inv_busy !== 1'b0)
      $display("FAIL rstmid_cycle: got we %b busy %b want 0 0", we, inv_busy); else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    n_dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (inv_done || inv_busy || we) n_dn++;
    end
    n_chk++; if (n_dn !== 0) $display("FAIL rstmid_after: got %0d active cycles want 0", n_dn); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n_wr;
    int dn_cyc[$];
    int wr_cyc[$];
    int n_err;
    clear_tlb(1'b1, 1'b0);
    tlb_g[5] = 1'b1; tlb_g[11] = 1'b1;
    n_err = 0;
    @(posedge clk); #1 inv_req = 1'b1; inv_op = 5'd0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      inv_req = (k == 4) || (k == 20);
      inv_op  = (k == 4) ? 5'd7 : 5'd2;
      @(negedge clk);
      if (we) wr_cyc.push_back(k);
      if (inv_done) begin dn_cyc.push_back(k); if (inv_err) n_err++; end
    end
    inv_req = 1'b0;
    n_wr = wr_cyc.size();
    n_chk++; if (n_wr !== 18) $display("FAIL b2b_nwrites: got %0d want 18", n_wr); else n_pass++;
    n_chk++; if (dn_cyc.size() !== 2) $display("FAIL b2b_ndone: got %0d want 2", dn_cyc.size()); else n_pass++;
    if (dn_cyc.size() == 2) begin
      n_chk++;
      if (dn_cyc[0] !== 17 || dn_cyc[1] !== 37)
        $display("FAIL b2b_done_cyc: got %0d,%0d want 17,37", dn_cyc[0], dn_cyc[1]);
      else n_pass++;
    end
    if (n_wr == 18) begin
      n_chk++;
      if (wr_cyc[16] !== 26 || wr_cyc[17] !== 32)
        $display("FAIL b2b_op2_cyc: got %0d,%0d want 26,32", wr_cyc[16], wr_cyc[17]);
      else n_pass++;
    end
    n_chk++; if (n_err !== 0) $display("FAIL b2b_err: got %0d want 0", n_err); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_op0_all;
    test_op4_asid;
    test_op5_va;
    test_op6_global;
    test_illegal;
    test_kill;
    test_reset_mid_walk;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlb_inv_seq.md
TLB_INV_SEQ -- requirements
Module: tlb_inv_seq

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, meaning the number of TLB entries walked (power of two, 4..32).
REQ-002 SHALL have clk  input  1  clock.
REQ-003 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have inv_req  input  1  WB stage requests an INVTLB operation.
REQ-005 SHALL have inv_op  input  5  INVTLB op code.
REQ-006 SHALL have inv_asid  input  10  ASID operand.
REQ-007 SHALL have inv_vppn  input  19  VA[31:13] operand.
REQ-008 SHALL have inv_kill  input  1  pipeline flush, which aborts the walk.
REQ-009 SHALL have inv_busy  output  1  walk in progress; WB holds ready_go low while this is high.
REQ-010 SHALL have inv_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have inv_err  output  1  valid only with inv_done: op code was illegal.
REQ-012 SHALL have r_index  output  log2(TLBNUM)  TLB read-port index.
REQ-013 SHALL have r_e, r_g, r_ps[5:0], r_asid[9:0], r_vppn[18:0]  input  as listed  combinational TLB read data for r_index.
REQ-014 SHALL have we, w_index  output  1 / log2(TLBNUM)  TLB write-port enable and index.
REQ-015 SHALL have w_e  output  1  written E bit, always 0.

Function
REQ-016 SHALL implement FSM states IDLE, WALK and DONE.
REQ-017 In IDLE with inv_req=1, SHALL accept: latch op/asid/vppn, clear idx to 0, then go to WALK if op<=6, else go to DONE with err latched to 1.
REQ-018 SHALL ignore inv_req outside IDLE; operands SHALL be used only from the latched copy.
REQ-019 In WALK, SHALL drive r_index=idx and evaluate one entry per cycle.
REQ-020 In WALK, SHALL assert we=1, w_index=idx, w_e=0 in the same cycle iff r_e=1 and match(op) is true; otherwise we=0.
REQ-021 SHALL define match as: op 0/1 true; op 2 r_g=1; op 3 r_g=0; op 4 r_g=0 && asid equal; op 5 r_g=0 && asid equal && va match; op 6 (r_g=1 || asid equal) && va match.
REQ-022 SHALL define va match as: if r_ps=12, r_vppn==vppn (all 19 bits); otherwise r_vppn[18:9]==vppn[18:9].
REQ-023 SHALL increment idx by 1 each WALK cycle; at idx==TLBNUM-1 SHALL go to DONE with no wrap-around write.
REQ-024 In DONE, SHALL assert inv_done=1 for exactly one cycle, drive inv_err=latched err, then return to IDLE.
REQ-025 SHALL drive inv_busy=1 in WALK and DONE and 0 in IDLE.
REQ-026 Latency: accept cycle T, writes possible in T+1..T+TLBNUM, inv_done at T+TLBNUM+1; illegal op gives inv_done at T+1 with zero writes.
REQ-027 When inv_kill=1 in any state, SHALL force we=0 that cycle, go to IDLE next cycle, and produce no inv_done; kill has priority over a same-cycle inv_req.
REQ-028 Outside WALK, SHALL hold we=0 and r_index=0.

Reset
REQ-029 On reset=1, SHALL set state=IDLE, idx=0, err=0 and latched operands=0.
REQ-030 Reset values of outputs SHALL be inv_busy=0, inv_done=0, inv_err=0, we=0, w_index=0, r_index=0, w_e=0.
REQ-031 Reset mid-walk SHALL abort immediately, with no write in the reset cycle.

Structure
REQ-032 A shared package SHALL hold the INVTLB op encodings (0..6), the FSM state enum, TLBNUM_DEFAULT=16 and the page-size constants PS_4K=12 and PS_2M=21.
REQ-033 The match logic SHALL be a combinational sub-module tlb_inv_match (inputs: op, latched asid/vppn, r_g/r_ps/r_asid/r_vppn; output: match).

Verification
REQ-034 Op 0, all 16 entries valid -> we high in 16 consecutive cycles with w_index 0..15, inv_done at T+17, inv_err=0.
REQ-035 Op 4 with asid=0x05, and entries 3 (g=0, asid 5), 7 (g=1, asid 5) and 9 (g=0, asid 6) valid -> exactly one write, at w_index 3.
REQ-036 Op 5 with asid=1 and vppn=0x12345; entry 2 (ps=12, vppn 0x12345), entry 4 (ps=21, vppn 0x12200) and entry 6 (ps=12, vppn 0x12344), all g=0 asid 1 -> writes at indices 2 and 4 only.
REQ-037 inv_op=7 -> inv_done with inv_err=1 at T+1, we never asserted.
REQ-038 inv_kill at idx=5 after writes at idx 0..4 -> no write at idx>=5, no inv_done, IDLE next cycle; a new req is accepted and runs to completion.
REQ-039 Second inv_req held during a walk -> ignored until IDLE, then accepted exactly once per pulse.
